// File: rtl/lane_scroller.sv
// Multi-lane obstacle X scroller with shared score-scaled prescaler; `LANE_SCROLLER_BOUNCE_EN` makes lanes bounce instead of wrap.
// Latency: counter match to o_Car_X/o_Tick/o_Wrap is 1 clock; no backpressure, i_Pause holds the counter and positions in place.
module lane_scroller #(
  parameter int NUM_LANES      = 5,
  parameter int X_WIDTH        = 10,
  parameter int H_VISIBLE_AREA = 640,
  parameter int TILE_SIZE      = 32,
  parameter int C_BASE_TICK    = 781250,
  parameter int TICK_WIDTH     = 20,
  parameter int SCORE_WIDTH    = 4,
  parameter int LEVEL_STEP     = 3,
  parameter int MAX_LEVEL      = 3
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst_N,
  input  logic                           i_Start,
  input  logic                           i_Pause,
  input  logic                           i_Load,
  input  logic [SCORE_WIDTH-1:0]         i_Score,
  input  logic [NUM_LANES-1:0]           i_Reverse,
  input  logic [3*NUM_LANES-1:0]         i_Speed_Mult,
  input  logic [X_WIDTH*NUM_LANES-1:0]   i_Init_X,
  output logic [X_WIDTH*NUM_LANES-1:0]   o_Car_X,
  output logic                           o_Tick,
  output logic [NUM_LANES-1:0]           o_Wrap,
  output logic [1:0]                     o_Level,
  output logic                           o_Running
);

  localparam int X_MAX = H_VISIBLE_AREA - TILE_SIZE;
  localparam logic [X_WIDTH:0] XMAX_W = (X_WIDTH+1)'(X_MAX);
  localparam logic [X_WIDTH:0] XLEN_W = (X_WIDTH+1)'(X_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE} state_t;

  state_t                 state;
  logic [TICK_WIDTH-1:0]  cnt;
  logic [TICK_WIDTH-1:0]  period_q;
  logic [X_WIDTH-1:0]     x_q    [NUM_LANES];
  logic [X_WIDTH-1:0]     x_nxt  [NUM_LANES];
  logic [X_WIDTH-1:0]     init_x [NUM_LANES];
  logic [NUM_LANES-1:0]   wrap_nxt;
  logic [SCORE_WIDTH-1:0] score_q;
  logic [1:0]             lvl;
  logic [TICK_WIDTH-1:0]  period_nxt;
  logic                   tick_match;
  logic                   count_en;
`ifdef LANE_SCROLLER_BOUNCE_EN
  logic [NUM_LANES-1:0]   flip_q;
  logic [NUM_LANES-1:0]   flip_nxt;
`endif

  // Difficulty level only takes effect when the counter restarts, so a
  // mid-period score change never shortens the period already in progress.
  assign score_q    = i_Score / SCORE_WIDTH'(LEVEL_STEP);
  assign lvl        = (score_q > SCORE_WIDTH'(MAX_LEVEL)) ? 2'(MAX_LEVEL) : score_q[1:0];
  assign period_nxt = TICK_WIDTH'(C_BASE_TICK) >> lvl;
  assign tick_match = (cnt == period_q - TICK_WIDTH'(1));
  assign count_en   = (state != S_IDLE) && !i_Pause;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane_io
      assign init_x[g] = i_Init_X[X_WIDTH*g +: X_WIDTH];
      assign o_Car_X[X_WIDTH*g +: X_WIDTH] = x_q[g];
    end
  endgenerate

  always_comb begin
    logic [X_WIDTH:0] x_w;
    logic [X_WIDTH:0] m_w;
    logic [X_WIDTH:0] sum_w;
    logic             dir;
    x_w      = '0;
    m_w      = '0;
    sum_w    = '0;
    dir      = 1'b0;
    wrap_nxt = '0;
`ifdef LANE_SCROLLER_BOUNCE_EN
    flip_nxt = flip_q;
`endif
    for (int k = 0; k < NUM_LANES; k++) begin
      x_w   = {1'b0, x_q[k]};
      m_w   = (X_WIDTH+1)'(i_Speed_Mult[3*k +: 3]);
      sum_w = x_w + m_w;
`ifdef LANE_SCROLLER_BOUNCE_EN
      dir = i_Reverse[k] ^ flip_q[k];
`else
      dir = i_Reverse[k];
`endif
      x_nxt[k] = x_q[k];
      if (!dir) begin
        if (sum_w > XMAX_W) begin
`ifdef LANE_SCROLLER_BOUNCE_EN
          x_nxt[k]    = X_WIDTH'(X_MAX);
          flip_nxt[k] = ~flip_q[k];
`else
          x_nxt[k] = X_WIDTH'(sum_w - XLEN_W);
`endif
          wrap_nxt[k] = 1'b1;
        end else begin
          x_nxt[k] = sum_w[X_WIDTH-1:0];
        end
      end else begin
        // m_w of zero can never exceed x_w, so a stationary lane never wraps
        if (x_w < m_w) begin
`ifdef LANE_SCROLLER_BOUNCE_EN
          x_nxt[k]    = '0;
          flip_nxt[k] = ~flip_q[k];
`else
          x_nxt[k] = X_WIDTH'(x_w + XLEN_W - m_w);
`endif
          wrap_nxt[k] = 1'b1;
        end else begin
          x_nxt[k] = X_WIDTH'(x_w - m_w);
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_N) begin
    if (!i_Rst_N) begin
      state     <= S_IDLE;
      cnt       <= '0;
      period_q  <= TICK_WIDTH'(C_BASE_TICK);
      o_Level   <= '0;
      o_Tick    <= 1'b0;
      o_Wrap    <= '0;
      o_Running <= 1'b0;
      for (int k = 0; k < NUM_LANES; k++) x_q[k] <= '0;
`ifdef LANE_SCROLLER_BOUNCE_EN
      flip_q    <= '0;
`endif
    end else begin
      o_Tick <= 1'b0;
      o_Wrap <= '0;
      if (i_Load) begin
        cnt      <= '0;
        period_q <= period_nxt;
        o_Level  <= lvl;
        for (int k = 0; k < NUM_LANES; k++) x_q[k] <= init_x[k];
`ifdef LANE_SCROLLER_BOUNCE_EN
        flip_q   <= '0;
`endif
      end
      unique case (state)
        S_IDLE: begin
          for (int k = 0; k < NUM_LANES; k++) x_q[k] <= init_x[k];
          if (i_Start && !i_Load) begin
            state     <= S_RUN;
            o_Running <= 1'b1;
          end
        end
        S_RUN, S_PAUSE: begin
          // Load holds the state; otherwise the pause level picks RUN/PAUSE
          if (!i_Load) begin
            state     <= i_Pause ? S_PAUSE : S_RUN;
            o_Running <= !i_Pause;
          end
          if (!i_Load && count_en) begin
            if (tick_match) begin
              cnt      <= '0;
              period_q <= period_nxt;
              o_Level  <= lvl;
              o_Tick   <= 1'b1;
              o_Wrap   <= wrap_nxt;
              for (int k = 0; k < NUM_LANES; k++) x_q[k] <= x_nxt[k];
`ifdef LANE_SCROLLER_BOUNCE_EN
              flip_q   <= flip_nxt;
`endif
            end else begin
              cnt <= cnt + TICK_WIDTH'(1);
            end
          end
        end
        default: begin
          state     <= S_IDLE;
          o_Running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_scroller.sv
// Directed bench for lane_scroller with an 8-clock base period and five lanes.
module tb_lane_scroller;
  localparam int NL = 5;
  localparam int XW = 10;

  logic            i_Clk = 1'b0;
  logic            i_Rst_N;
  logic            i_Start;
  logic            i_Pause;
  logic            i_Load;
  logic [3:0]      i_Score;
  logic [NL-1:0]   i_Reverse;
  logic [3*NL-1:0] i_Speed_Mult;
  logic [XW*NL-1:0] i_Init_X;
  logic [XW*NL-1:0] o_Car_X;
  logic            o_Tick;
  logic [NL-1:0]   o_Wrap;
  logic [1:0]      o_Level;
  logic            o_Running;

  always #5 i_Clk = ~i_Clk;

  lane_scroller #(.C_BASE_TICK(8)) dut (
    .i_Clk(i_Clk), .i_Rst_N(i_Rst_N), .i_Start(i_Start), .i_Pause(i_Pause),
    .i_Load(i_Load), .i_Score(i_Score), .i_Reverse(i_Reverse),
    .i_Speed_Mult(i_Speed_Mult), .i_Init_X(i_Init_X), .o_Car_X(o_Car_X),
    .o_Tick(o_Tick), .o_Wrap(o_Wrap), .o_Level(o_Level), .o_Running(o_Running)
  );

  int checks = 0;
  int fails  = 0;
  logic [XW-1:0] init_v [NL];
  logic [2:0]    mult_v [NL];

  function automatic logic [XW-1:0] car(int k);
    return o_Car_X[XW*k +: XW];
  endfunction

  function automatic logic [XW*NL-1:0] init_packed();
    logic [XW*NL-1:0] p;
    for (int k = 0; k < NL; k++) p[XW*k +: XW] = init_v[k];
    return p;
  endfunction

  task automatic apply();
    i_Init_X = init_packed();
    for (int k = 0; k < NL; k++) i_Speed_Mult[3*k +: 3] = mult_v[k];
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge i_Clk);
      #1;
    end
  endtask

  // Clocks until o_Tick is seen; -1 if it never arrives within the budget.
  task automatic wait_tick(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      n++;
      if (o_Tick) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  task automatic pulse_load();
    i_Load = 1'b1;
    step(1);
    i_Load = 1'b0;
  endtask

  task automatic test_reset();
    i_Rst_N = 1'b0; i_Start = 0; i_Pause = 0; i_Load = 0; i_Score = 0; i_Reverse = '0;
    init_v = '{10'd32, 10'd320, 10'd160, 10'd416, 10'd544};
    mult_v = '{3'd2, 3'd4, 3'd2, 3'd1, 3'd2};
    apply();
    #22;
    checks++; if (o_Car_X !== '0) begin fails++; $display("FAIL reset_x got %h want 0", o_Car_X); end
    checks++; if (o_Tick !== 1'b0) begin fails++; $display("FAIL reset_tick got %b want 0", o_Tick); end
    checks++; if (o_Wrap !== '0) begin fails++; $display("FAIL reset_wrap got %b want 0", o_Wrap); end
    checks++; if (o_Running !== 1'b0) begin fails++; $display("FAIL reset_running got %b want 0", o_Running); end
    checks++; if (o_Level !== 2'd0) begin fails++; $display("FAIL reset_level got %0d want 0", o_Level); end
    @(negedge i_Clk);
    i_Rst_N = 1'b1;
    step(1);
    checks++; if (o_Car_X !== init_packed()) begin fails++; $display("FAIL idle_follow got %h want %h", o_Car_X, init_packed()); end
  endtask

  task automatic test_first_tick();
    int n;
    i_Start = 1'b1;
    step(1);
    i_Start = 1'b0;
    checks++; if (o_Running !== 1'b1) begin fails++; $display("FAIL start_running got %b want 1", o_Running); end
    wait_tick(n);
    checks++; if (n != 8) begin fails++; $display("FAIL first_tick_latency got %0d want 8", n); end
    checks++; if (car(0) !== 10'd34) begin fails++; $display("FAIL first_lane0 got %0d want 34", car(0)); end
    checks++; if (car(1) !== 10'd324) begin fails++; $display("FAIL first_lane1 got %0d want 324", car(1)); end
    checks++; if (o_Level !== 2'd0) begin fails++; $display("FAIL first_level got %0d want 0", o_Level); end
    checks++; if (o_Wrap !== 5'b0) begin fails++; $display("FAIL first_wrap got %b want 0", o_Wrap); end
  endtask

  task automatic test_wrap_fwd();
    int n;
    init_v[4] = 10'd607;
    apply();
    pulse_load();
    checks++; if (car(4) !== 10'd607 || o_Tick !== 1'b0) begin fails++; $display("FAIL load_lane4 got %0d tick %b want 607 tick 0", car(4), o_Tick); end
    wait_tick(n);
    checks++; if (n != 8) begin fails++; $display("FAIL load_restart got %0d want 8", n); end
    // 607 + 2 - 609 lands exactly on 0
    checks++; if (car(4) !== 10'd0) begin fails++; $display("FAIL fwd_wrap_x got %0d want 0", car(4)); end
    checks++; if (o_Wrap !== 5'b10000) begin fails++; $display("FAIL fwd_wrap_bits got %b want 10000", o_Wrap); end
    checks++; if (car(0) !== 10'd34) begin fails++; $display("FAIL fwd_lane0 got %0d want 34", car(0)); end
  endtask

  task automatic test_wrap_rev();
    int n;
    init_v[4] = 10'd544;
    init_v[3] = 10'd0;
    i_Reverse = 5'b01000;
    apply();
    pulse_load();
    wait_tick(n);
    checks++; if (car(3) !== 10'd608) begin fails++; $display("FAIL rev_wrap_x got %0d want 608", car(3)); end
    checks++; if (o_Wrap !== 5'b01000) begin fails++; $display("FAIL rev_wrap_bits got %b want 01000", o_Wrap); end
    mult_v[3] = 3'd0;
    apply();
    wait_tick(n);
    checks++; if (car(3) !== 10'd608) begin fails++; $display("FAIL stationary_x got %0d want 608", car(3)); end
    checks++; if (o_Wrap !== 5'b0) begin fails++; $display("FAIL stationary_wrap got %b want 0", o_Wrap); end
    checks++; if (car(4) !== 10'd548) begin fails++; $display("FAIL rev_lane4 got %0d want 548", car(4)); end
    i_Reverse = '0;
    mult_v[3] = 3'd1;
    apply();
  endtask

  task automatic test_level();
    int n;
    step(3);
    i_Score = 4'd7;
    wait_tick(n);
    checks++; if (n != 5) begin fails++; $display("FAIL level_mid_period got %0d want 5", n); end
    checks++; if (o_Level !== 2'd2) begin fails++; $display("FAIL level2 got %0d want 2", o_Level); end
    wait_tick(n);
    checks++; if (n != 2) begin fails++; $display("FAIL period_lvl2 got %0d want 2", n); end
    i_Score = 4'd15;
    wait_tick(n);
    checks++; if (n != 2 || o_Level !== 2'd3) begin fails++; $display("FAIL clamp_first got %0d lvl %0d want 2 lvl 3", n, o_Level); end
    wait_tick(n);
    checks++; if (n != 1) begin fails++; $display("FAIL period_lvl3 got %0d want 1", n); end
    i_Score = 4'd0;
    wait_tick(n);
    checks++; if (o_Level !== 2'd0) begin fails++; $display("FAIL level_back0 got %0d want 0", o_Level); end
  endtask

  task automatic test_pause();
    int n;
    bit seen;
    logic [XW*NL-1:0] snap;
    pulse_load();
    step(5);
    snap = o_Car_X;
    seen = 1'b0;
    i_Pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (o_Tick) seen = 1'b1;
    end
    checks++; if (seen) begin fails++; $display("FAIL pause_tick got 1 want 0"); end
    checks++; if (o_Car_X !== snap) begin fails++; $display("FAIL pause_x got %h want %h", o_Car_X, snap); end
    checks++; if (o_Running !== 1'b0) begin fails++; $display("FAIL pause_running got %b want 0", o_Running); end
    i_Pause = 1'b0;
    wait_tick(n);
    checks++; if (n != 3) begin fails++; $display("FAIL pause_resume got %0d want 3", n); end
    checks++; if (o_Running !== 1'b1 || car(0) !== 10'd34) begin fails++; $display("FAIL resume_state run %b x0 %0d want 1 34", o_Running, car(0)); end
  endtask

  task automatic test_load_on_tick();
    int n;
    pulse_load();
    step(7);
    i_Load = 1'b1;
    step(1);
    i_Load = 1'b0;
    checks++; if (o_Tick !== 1'b0) begin fails++; $display("FAIL load_tick got %b want 0", o_Tick); end
    checks++; if (o_Car_X !== init_packed()) begin fails++; $display("FAIL load_x got %h want %h", o_Car_X, init_packed()); end
    wait_tick(n);
    checks++; if (n != 8) begin fails++; $display("FAIL load_counter got %0d want 8", n); end
  endtask

  task automatic test_async_reset();
    i_Score = 4'd15;
    pulse_load();
    step(3);
    checks++; if (o_Level !== 2'd3) begin fails++; $display("FAIL pre_reset_level got %0d want 3", o_Level); end
    #3;
    i_Rst_N = 1'b0;
    #1;
    checks++; if (o_Car_X !== '0) begin fails++; $display("FAIL async_x got %h want 0", o_Car_X); end
    checks++; if (o_Running !== 1'b0 || o_Tick !== 1'b0) begin fails++; $display("FAIL async_ctl run %b tick %b want 0 0", o_Running, o_Tick); end
    checks++; if (o_Level !== 2'd0) begin fails++; $display("FAIL async_level got %0d want 0", o_Level); end
    i_Rst_N = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_wrap_fwd();
    test_wrap_rev();
    test_level();
    test_pause();
    test_load_on_tick();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
